// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - NCH:1 stream mux, manual or round-robin select, registered output.
// Optional STREAM_MUX_STATS_EN adds xfer_count and ch_starved outputs.
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef STREAM_MUX_STATS_EN
  ,
  output logic [15:0]          xfer_count,
  output logic [NCH-1:0]       ch_starved
`endif
);

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_chan;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_grant_valid;
  logic [SELW-1:0]  w_grant;
  logic             w_xfer;
  logic [WIDTH-1:0] w_sel_data;

  assign w_load = ~r_out_valid | out_ready;

  // Round-robin scans from farthest to nearest so the nearest valid channel after ptr wins.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    if (!mode) begin
      for (int k = 0; k < NCH; k++) begin
        if (sel == SELW'(k) && in_valid[k]) begin
          w_grant_valid = 1'b1;
          w_grant       = SELW'(k);
        end
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        if (in_valid[(int'(r_ptr) + i) % NCH]) begin
          w_grant_valid = 1'b1;
          w_grant       = SELW'((int'(r_ptr) + i) % NCH);
        end
      end
    end
  end

  assign w_xfer     = w_load & w_grant_valid;
  assign w_sel_data = in_data[int'(w_grant)*WIDTH +: WIDTH];

  always_comb begin
    in_ready = '0;
    if (w_xfer) in_ready[w_grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_chan  <= '0;
      r_ptr       <= SELW'(NCH - 1);
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_chan  <= w_grant;
      r_ptr       <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_chan  = r_out_chan;
  assign out_valid = r_out_valid;

`ifdef STREAM_MUX_STATS_EN
  logic [15:0]    r_xfer_count;
  logic [3:0]     r_starve_cnt [NCH];
  logic [NCH-1:0] r_starved;

  // A channel counts as starved on its 16th consecutive valid-but-ungranted cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xfer_count <= '0;
      r_starved    <= '0;
      for (int k = 0; k < NCH; k++) r_starve_cnt[k] <= '0;
    end else begin
      if (r_out_valid && out_ready && r_xfer_count != 16'hFFFF)
        r_xfer_count <= r_xfer_count + 16'd1;
      for (int k = 0; k < NCH; k++) begin
        if (in_valid[k] && !(w_grant_valid && w_grant == SELW'(k))) begin
          if (r_starve_cnt[k] == 4'd15) r_starved[k] <= 1'b1;
          else r_starve_cnt[k] <= r_starve_cnt[k] + 4'd1;
        end else begin
          r_starve_cnt[k] <= '0;
        end
      end
    end
  end

  assign xfer_count = r_xfer_count;
  assign ch_starved = r_starved;
`endif

endmodule

// File: doc/stream_mux_arb.md
Name: stream_mux_arb

Overview:
Parametrised successor to the 4:1 ALU operand multiplexer. Selects one of NCH WIDTH-bit input channels and presents it on a registered output with valid/ready handshake on every side. Two selection modes are supported:
- manual: the select input chooses the channel.
- round-robin: a fair arbiter chooses the channel.
Sits between ALU operand sources and downstream datapath stages that may stall.

Parameters:
WIDTH, 8, data width per channel in bits
NCH, 4, number of input channels, ≥2
SELW, 2, select/channel-index width; must equal ceil(log2(NCH))

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
mode  input  1  0 = manual select, 1 = round-robin
sel  input  SELW  channel index used in manual mode; values ≥NCH grant nothing
in_data  input  NCH*WIDTH  channel k occupies bits [k*WIDTH+WIDTH-1 : k*WIDTH]
in_valid  input  NCH  per-channel data valid
in_ready  output  NCH  per-channel accept, at most one bit high, combinational
out_data  output  WIDTH  registered selected data
out_chan  output  SELW  index of the channel that produced out_data
out_valid  output  1  out_data/out_chan valid
out_ready  input  1  downstream accept

Behaviour:
- Reset (async, any time, including mid-transfer):
  - out_valid=0, out_data=0, out_chan=0.
  - last-grant pointer = NCH-1, so the first round-robin search starts at channel 0.
  - Any in-flight word is dropped.
- load = ~out_valid | out_ready. The output register can accept a new word this cycle.
- Grant, combinational:
  - mode=0: grant channel g=sel if sel<NCH and in_valid[sel]=1; otherwise no grant.
  - mode=1: g = first k with in_valid[k]=1, searching (ptr+1), (ptr+2), … with wrap NCH-1→0, ptr included last. No valid input means no grant.
- in_ready[g] = load & grant_valid. All other in_ready bits are 0. in_ready never depends on in_data.
- Transfer on input side: in_valid[g] & in_ready[g].
  - Next edge: out_data←channel g data, out_chan←g, out_valid←1.
  - Latency: exactly 1 cycle from accepted input to out_valid.
- Output drain: out_valid & out_ready with no new transfer → out_valid←0 next edge. out_data and out_chan hold their last values.
- Simultaneous drain and load in one cycle → new word registered, out_valid stays 1. Full throughput is 1 word/cycle.
- Stall: out_valid=1 & out_ready=0 → out_data, out_chan and out_valid held stable; all in_ready=0.
- ptr updates to g only on an input transfer, in either mode. Switching mode does not reset ptr; the new mode applies to the same-cycle grant.
- sel or mode changes while stalled have no effect on the held output.
- Output data is never altered while out_valid=1 & out_ready=0.

Optional Feature:
STREAM_MUX_STATS_EN
- Defined:
  - Adds output port xfer_count, 16 bits: count of output transfers (out_valid & out_ready).
  - Saturates at 16'hFFFF; cleared to 0 by rst.
  - Adds output port ch_starved, NCH bits: bit k set when channel k has had in_valid=1 without grant for 16 consecutive cycles.
  - ch_starved is sticky until rst.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset mid-stream: out_valid=1 holding 8'hA5, assert rst asynchronously between edges → out_valid, out_data, out_chan read 0 immediately, before the next clock edge.
2. Manual mode: mode=0, sel=2, all in_valid=1, data k=8'h10+k, out_ready=1 → in_ready=4'b0100; next cycle out_data=8'h12, out_chan=2; sel=3 next → 8'h13 one cycle later.
3. Round-robin fairness: mode=1, in_valid=4'b1111, out_ready=1, 8 cycles after reset → out_chan sequence 0,1,2,3,0,1,2,3, one word per cycle.
4. Sparse round-robin with wrap: in_valid=4'b1001, start after reset → grants 0,3,0,3; drop in_valid[0] → only 3 repeatedly.
5. Backpressure: out_ready=0 for 5 cycles with out_valid=1, data 8'h7E → out_data stays 8'h7E, in_ready=0 throughout; out_ready=1 → next queued word appears the following cycle with no loss or duplication.
6. STREAM_MUX_STATS_EN defined: 20 transfers then rst → xfer_count=20 before rst, 0 after. Channel 3 valid but masked by mode=0, sel=0 for 16 cycles → ch_starved[3]=1.
